functional_unit_buf: RTL

- Parametrised successor to the DySER functional unit.
- Four directional data inputs (NW/NE/SE/SW); `conf` selects two operand inputs and an operation. The result drives `d_out_SE`.
- Adds per-input credit buffers of depth `BUF_DEPTH`, a downstream credit counter allowing `OUT_CREDITS` results in flight, and a 3-bit op field.
- Sits in the switch/FU mesh. Flow control is credit-based throughout.

---
 rtl/dyser_fu_pkg.sv | 43 ++++
 rtl/fu_in_fifo.sv | 68 ++++++
 rtl/functional_unit_buf.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dyser_fu_pkg.sv
// Shared definitions for the buffered DySER functional unit: op codes,
// direction codes and the layout of the conf word.
package dyser_fu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    DIR_NW = 2'b00,
    DIR_NE = 2'b01,
    DIR_SW = 2'b10,
    DIR_SE = 2'b11
  } dir_e;

  localparam int NUM_PORTS     = 4;
  localparam int CONF_W        = 7;
  localparam int CONF_SEL_W    = 2;
  localparam int CONF_OP_W     = 3;
  localparam int CONF_SEL1_LSB = 0;
  localparam int CONF_SEL0_LSB = 2;
  localparam int CONF_OP_LSB   = 4;

  function automatic logic [CONF_SEL_W-1:0] conf_sel0(input logic [CONF_W-1:0] conf);
    return conf[CONF_SEL0_LSB +: CONF_SEL_W];
  endfunction

  function automatic logic [CONF_SEL_W-1:0] conf_sel1(input logic [CONF_W-1:0] conf);
    return conf[CONF_SEL1_LSB +: CONF_SEL_W];
  endfunction

  function automatic op_e conf_op(input logic [CONF_W-1:0] conf);
    return op_e'(conf[CONF_OP_LSB +: CONF_OP_W]);
  endfunction

endpackage

// File: rtl/fu_in_fifo.sv
// Per-port input credit buffer: circular FIFO with a combinational head so the
// functional unit can fire in the same cycle an entry becomes the oldest.
module fu_in_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full buffer still accepts a push when its head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/functional_unit_buf.sv
// Buffered DySER functional unit: two conf-selected operand buffers feed an ALU
// whose registered result drives d_out_SE under downstream credit control.
// Optional FU_PROTOCOL_CHECK_EN adds a sticky err output for protocol violations.
module functional_unit_buf
  import dyser_fu_pkg::*;
#(
  parameter int PATH_WIDTH  = 64,
  parameter int BUF_DEPTH   = 2,
  parameter int OUT_CREDITS = 2,
  parameter int FU_ID       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PATH_WIDTH:0] d_in_NW,
  input  logic [PATH_WIDTH:0] d_in_NE,
  input  logic [PATH_WIDTH:0] d_in_SE,
  input  logic [PATH_WIDTH:0] d_in_SW,
  input  logic                c_in_SE,
  input  logic [6:0]          conf,
  output logic                c_out_NW,
  output logic                c_out_NE,
  output logic                c_out_SE,
  output logic                c_out_SW,
  output logic [PATH_WIDTH:0] d_out_SE
`ifdef FU_PROTOCOL_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int SHAMT_W = (PATH_WIDTH > 1) ? $clog2(PATH_WIDTH) : 1;
  localparam int CNT_W   = $clog2(OUT_CREDITS + 1);

  // The instance identifier only tags the unit in the mesh.
  if (FU_ID < 0) begin : g_fu_id_tag
  end

  logic [PATH_WIDTH:0]   d_in_a     [NUM_PORTS];
  logic [PATH_WIDTH-1:0] in_data    [NUM_PORTS];
  logic [PATH_WIDTH-1:0] fifo_head  [NUM_PORTS];
  logic [PATH_WIDTH-1:0] head_eff   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_vld;
  logic [NUM_PORTS-1:0]  port_sel;
  logic [NUM_PORTS-1:0]  avail;
  logic [NUM_PORTS-1:0]  consume;
  logic [NUM_PORTS-1:0]  bypass;
  logic [NUM_PORTS-1:0]  fifo_push;
  logic [NUM_PORTS-1:0]  fifo_pop;
  logic [NUM_PORTS-1:0]  fifo_empty;
  logic [NUM_PORTS-1:0]  fifo_full;
  logic [NUM_PORTS-1:0]  c_out_q, c_out_d;

  logic [CONF_SEL_W-1:0] sel0, sel1;
  op_e                   op;
  logic                  fire;
  logic [PATH_WIDTH-1:0] op0, op1;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cnt_full;
  logic [PATH_WIDTH-1:0] dout_data_q, dout_data_d;
  logic                  dout_vld_q, dout_vld_d;

  assign d_in_a[DIR_NW] = d_in_NW;
  assign d_in_a[DIR_NE] = d_in_NE;
  assign d_in_a[DIR_SW] = d_in_SW;
  assign d_in_a[DIR_SE] = d_in_SE;

  assign sel0 = conf_sel0(conf);
  assign sel1 = conf_sel1(conf);
  assign op   = conf_op(conf);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign in_vld[gi]   = d_in_a[gi][0];
    assign in_data[gi]  = d_in_a[gi][PATH_WIDTH:1];
    assign port_sel[gi] = (sel0 == CONF_SEL_W'(gi)) || (sel1 == CONF_SEL_W'(gi));
    // An arriving word counts as available at once so an empty path costs one cycle.
    assign avail[gi]    = !fifo_empty[gi] || in_vld[gi];
    assign head_eff[gi] = fifo_empty[gi] ? in_data[gi] : fifo_head[gi];
    assign consume[gi]  = fire && port_sel[gi];
    assign bypass[gi]   = consume[gi] && fifo_empty[gi];
    assign fifo_pop[gi] = consume[gi] && !fifo_empty[gi];
    assign fifo_push[gi] = in_vld[gi] && port_sel[gi] && !bypass[gi] &&
                           (!fifo_full[gi] || fifo_pop[gi]);
    // Dropped words on unselected ports still hand their credit back.
    assign c_out_d[gi]  = consume[gi] || (in_vld[gi] && !port_sel[gi]);

    fu_in_fifo #(
      .WIDTH (PATH_WIDTH),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[gi]),
      .data_i  (in_data[gi]),
      .pop_i   (fifo_pop[gi]),
      .head_o  (fifo_head[gi]),
      .empty_o (fifo_empty[gi]),
      .full_o  (fifo_full[gi])
    );
  end

  assign cnt_full = (cnt_q == CNT_W'(OUT_CREDITS));
  assign fire     = avail[sel0] && avail[sel1] && (cnt_q != '0);
  assign op0      = head_eff[sel0];
  assign op1      = head_eff[sel1];

  function automatic logic [PATH_WIDTH-1:0] alu(input op_e f,
                                                input logic [PATH_WIDTH-1:0] a,
                                                input logic [PATH_WIDTH-1:0] b);
    logic [SHAMT_W-1:0] shamt;
    shamt = b[SHAMT_W-1:0];
    case (f)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SHL:  alu = a << shamt;
      OP_SHR:  alu = a >> shamt;
      default: alu = a;
    endcase
  endfunction

  always_comb begin
    dout_data_d = dout_data_q;
    dout_vld_d  = fire;
    cnt_d       = cnt_q;
    if (fire) begin
      dout_data_d = alu(op, op0, op1);
    end
    if (fire && !c_in_SE) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!fire && c_in_SE && !cnt_full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_data_q <= '0;
      dout_vld_q  <= 1'b0;
      cnt_q       <= CNT_W'(OUT_CREDITS);
      c_out_q     <= '0;
    end else begin
      dout_data_q <= dout_data_d;
      dout_vld_q  <= dout_vld_d;
      cnt_q       <= cnt_d;
      c_out_q     <= c_out_d;
    end
  end

  assign d_out_SE = {dout_data_q, dout_vld_q};
  assign c_out_NW = c_out_q[DIR_NW];
  assign c_out_NE = c_out_q[DIR_NE];
  assign c_out_SW = c_out_q[DIR_SW];
  assign c_out_SE = c_out_q[DIR_SE];

`ifdef FU_PROTOCOL_CHECK_EN
  logic [NUM_PORTS-1:0] overflow;
  logic                 err_q, err_d;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ovf
    assign overflow[gi] = in_vld[gi] && port_sel[gi] && !bypass[gi] &&
                          fifo_full[gi] && !fifo_pop[gi];
  end

  always_comb begin
    err_d = err_q;
    if ((|overflow) || (c_in_SE && cnt_full)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
